// File: rtl/alu_exec_stage.sv
// Single-issue ALU execute stage with a valid/ready handshake and a one-deep result register.
// Define ALU_MUL_EN to build in the 32-cycle iterative unsigned multiplier (code 0011).
module alu_exec_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  alu_control,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        zero,
   output logic        busy
);

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 5;

   localparam logic [3:0] OP_OR   = 4'b0000;
   localparam logic [3:0] OP_AND  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;

   logic          accept;
   logic          is_mul;
   logic          mul_done;
   logic [DW-1:0] mul_product;
   logic [DW-1:0] alu_val;

   // Reset holds the stage closed so nothing is accepted while it is asserted.
   assign in_ready = !reset && !busy && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // Single-cycle datapath; unlisted codes produce zero.
   always_comb begin
      alu_val = '0;
      case (alu_control)
         OP_OR:   alu_val = op_a | op_b;
         OP_AND:  alu_val = op_a & op_b;
         OP_ADD:  alu_val = op_a + op_b;
         OP_XOR:  alu_val = op_a ^ op_b;
         OP_SUB:  alu_val = op_a - op_b;
         OP_SLT:  alu_val = DW'($signed(op_a) < $signed(op_b));
         OP_SLTU: alu_val = DW'(op_a < op_b);
         default: alu_val = '0;
      endcase
   end

`ifdef ALU_MUL_EN
   typedef enum logic {IDLE, MUL} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] mcand_q, mcand_d;
   logic [DW-1:0] mplier_q, mplier_d;
   logic [DW-1:0] acc_q, acc_d;

   assign is_mul = (alu_control == 4'b0011);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         busy     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         busy     <= (state_d == MUL);
      end
   end

   // Shift-add: one multiplier bit per cycle, operands captured at acceptance.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      mul_done    = 1'b0;
      mul_product = '0;
      case (state_q)
         IDLE: begin
            if (accept && is_mul) begin
               state_d  = MUL;
               cnt_d    = '0;
               mcand_d  = op_a;
               mplier_d = op_b;
               acc_d    = '0;
            end
         end
         MUL: begin
            acc_d       = acc_q + (mplier_q[0] ? mcand_q : DW'(0));
            mcand_d     = mcand_q << 1;
            mplier_d    = mplier_q >> 1;
            cnt_d       = cnt_q + CW'(1);
            mul_product = acc_d;
            if (cnt_q == CW'(31)) begin
               state_d  = IDLE;
               cnt_d    = '0;
               mul_done = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end
`else
   assign is_mul      = 1'b0;
   assign mul_done    = 1'b0;
   assign mul_product = '0;
   assign busy        = 1'b0;
`endif

   // Result register: new acceptance or multiplier completion loads, a consumed result clears.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b1;
      end else if (accept && !is_mul) begin
         out_valid <= 1'b1;
         result    <= alu_val;
         zero      <= (alu_val == '0);
      end else if (mul_done) begin
         out_valid <= 1'b1;
         result    <= mul_product;
         zero      <= (mul_product == '0);
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: stimulus pushes expected results, a monitor pops them on each transfer.
// Multiplier checks are compiled in when ALU_MUL_EN is defined.
module tb_alu_exec_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  alu_control = 4'h0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        zero;
   logic        busy;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   bit          busy_seen = 1'b0;
   logic [31:0] exp_q[$];
   int          xfer_cyc[$];

   alu_exec_stage dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .alu_control(alu_control), .op_a(op_a), .op_b(op_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: a transfer is out_valid && out_ready seen at the negedge before the consuming edge.
   always @(negedge clk) begin
      logic [31:0] e;
      if (busy === 1'b1) busy_seen = 1'b1;
      if (!reset && out_valid === 1'b1 && out_ready) begin
         xfer_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_xfer actual=%h required=<none>", result);
         end else begin
            e = exp_q.pop_front();
            chk("result", result, e);
            chk("zero", 32'(zero), 32'(e == 32'h0));
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic issue(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expv, input bit push);
      int n;
      in_valid = 1'b1;
      alu_control = code;
      op_a = a;
      op_b = b;
      if (push) exp_q.push_back(expv);
      n = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 200) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      alu_control = 4'hF;
      op_a = 32'hDEAD_BEEF;
      op_b = 32'h1234_5678;
   endtask

   initial begin
      int xn;
      int nb;
      bit ov_seen;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_zero", 32'(zero), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;

      // ADD wrap with latency 1
      issue(4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1);
      chk("add_latency_valid", 32'(out_valid), 32'd1);
      issue(4'b0111, 32'hFFFF_FFFE, 32'h1, 32'h1, 1'b1);
      issue(4'b1000, 32'hFFFF_FFFE, 32'h1, 32'h0, 1'b1);
      issue(4'b0110, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b1);
      issue(4'b0010, 32'h8000_0000, 32'h8000_0000, 32'h0, 1'b1);
      issue(4'b0111, 32'h1, 32'h8000_0000, 32'h0, 1'b1);
      issue(4'b1111, 32'h1234_5678, 32'h1, 32'h0, 1'b1);
      issue(4'b0101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1);
      repeat (2) @(posedge clk);
      #1;

      // Streaming OR, AND, XOR, SUB back to back
      xfer_cyc.delete();
      issue(4'b0000, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b1);
      issue(4'b0001, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b1);
      issue(4'b0100, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b1);
      issue(4'b0110, 32'd10, 32'd3, 32'd7, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("stream_count", 32'(xfer_cyc.size()), 32'd4);
      if (xfer_cyc.size() == 4) chk("stream_span", 32'(xfer_cyc[3] - xfer_cyc[0]), 32'd3);

      // Backpressure: result held for 5 cycles, then exactly one transfer
      out_ready = 1'b0;
      issue(4'b0010, 32'd5, 32'd7, 32'd12, 1'b1);
      xn = xfer_cyc.size();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         chk("hold_result", result, 32'd12);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("hold_one_xfer", 32'(xfer_cyc.size()), 32'(xn + 1));
      chk("hold_cleared", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;

`ifdef ALU_MUL_EN
      // Multiply: busy for exactly 32 cycles, then product
      issue(4'b0011, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001, 1'b1);
      nb = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid) break;
         if (busy) begin
            nb++;
            chk("mul_in_ready", 32'(in_ready), 32'd0);
         end
      end
      chk("mul_busy_cycles", 32'(nb), 32'd32);
      repeat (2) @(posedge clk);
      #1;

      // Reset mid-multiply aborts with no result
      issue(4'b0011, 32'h0001_0001, 32'h0001_0001, 32'h0, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      chk("abort_busy", 32'(busy), 32'd0);
      ov_seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) ov_seen = 1'b1;
      end
      chk("abort_no_valid", 32'(ov_seen), 32'd0);
      @(posedge clk);
      #1;
`else
      // Code 0011 behaves as undefined: zero after one cycle, never busy
      issue(4'b0011, 32'd3, 32'd5, 32'h0, 1'b1);
      chk("mul_off_latency", 32'(out_valid), 32'd1);
      repeat (3) @(negedge clk);
      chk("mul_off_busy", 32'(busy_seen), 32'd0);
      @(posedge clk);
      #1;
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
